// File: rtl/reg_mem_arbiter_pkg.sv
// Shared types for the two-port reg_mem arbiter: FSM state encoding and port identifiers.
package reg_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/reg_mem.sv
// Simple register memory shared by the arbiter clients: combinational read, posedge write.
module reg_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] memArray_q [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wen) begin
      memArray_q[addr] <= data_in;
    end
  end

  assign data_out = memArray_q[addr];

endmodule

// File: rtl/reg_mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: on contention the port that did not win last time is chosen.
module rr_pick2
  import reg_mem_arbiter_pkg::*;
(
  input  logic  req_a_i,
  input  logic  req_b_i,
  input  port_e last_owner_i,
  output logic  gnt_a_o,
  output logic  gnt_b_o
);

  always_comb begin
    gnt_a_o = req_a_i & (~req_b_i | (last_owner_i == PORT_B));
    gnt_b_o = req_b_i & ~gnt_a_o;
  end

endmodule

// File: rtl/reg_mem_arbiter.sv
// Two-port round-robin sequencer sharing one reg_mem: grant in IDLE, one ACCESS cycle,
// then a registered done pulse (with read data for reads) on the following IDLE cycle.
module reg_mem_arbiter
  import reg_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_BITS-1:0]  addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  done_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_BITS-1:0]  addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  done_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  port_e                 lastOwner_q, lastOwner_d;
  port_e                 cmdOwner_q, cmdOwner_d;
  logic                  cmdWe_q, cmdWe_d;
  logic [ADDR_BITS-1:0]  cmdAddr_q, cmdAddr_d;
  logic [DATA_WIDTH-1:0] cmdWdata_q, cmdWdata_d;
  logic                  doneA_q, doneA_d, doneB_q, doneB_d;
  logic [DATA_WIDTH-1:0] rdataA_q, rdataA_d, rdataB_q, rdataB_d;
  logic                  pickA, pickB;

  rr_pick2 u_pick (
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .last_owner_i (lastOwner_q),
    .gnt_a_o      (pickA),
    .gnt_b_o      (pickB)
  );

  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
    cmdOwner_d  = cmdOwner_q;
    cmdWe_d     = cmdWe_q;
    cmdAddr_d   = cmdAddr_q;
    cmdWdata_d  = cmdWdata_q;
    doneA_d     = 1'b0;
    doneB_d     = 1'b0;
    rdataA_d    = rdataA_q;
    rdataB_d    = rdataB_q;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wen     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && (pickA || pickB)) begin
          gnt_a       = pickA;
          gnt_b       = pickB;
          state_d     = ST_ACCESS;
          lastOwner_d = pickA ? PORT_A : PORT_B;
          cmdOwner_d  = pickA ? PORT_A : PORT_B;
          cmdWe_d     = pickA ? we_a : we_b;
          cmdAddr_d   = pickA ? addr_a : addr_b;
          cmdWdata_d  = pickA ? wdata_a : wdata_b;
        end
      end
      ST_ACCESS: begin
        // wen is gated by rst_n so a write aborted by reset never reaches the memory
        mem_addr  = cmdAddr_q;
        mem_wdata = cmdWdata_q;
        mem_wen   = cmdWe_q & rst_n;
        state_d   = ST_IDLE;
        if (cmdOwner_q == PORT_A) begin
          doneA_d = 1'b1;
          if (!cmdWe_q) rdataA_d = mem_rdata;
        end else begin
          doneB_d = 1'b1;
          if (!cmdWe_q) rdataB_d = mem_rdata;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lastOwner_q <= PORT_B;
      cmdOwner_q  <= PORT_A;
      cmdWe_q     <= 1'b0;
      cmdAddr_q   <= '0;
      cmdWdata_q  <= '0;
      doneA_q     <= 1'b0;
      doneB_q     <= 1'b0;
      rdataA_q    <= '0;
      rdataB_q    <= '0;
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
      cmdOwner_q  <= cmdOwner_d;
      cmdWe_q     <= cmdWe_d;
      cmdAddr_q   <= cmdAddr_d;
      cmdWdata_q  <= cmdWdata_d;
      doneA_q     <= doneA_d;
      doneB_q     <= doneB_d;
      rdataA_q    <= rdataA_d;
      rdataB_q    <= rdataB_d;
    end
  end

  assign done_a  = doneA_q;
  assign done_b  = doneB_q;
  assign rdata_a = rdataA_q;
  assign rdata_b = rdataB_q;

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// Randomized and directed bench for reg_mem_arbiter + reg_mem against a transaction-level model.
module tb_reg_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, we_a, req_b, we_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, done_a, done_b, mem_wen;
  logic [7:0] rdata_a, rdata_b, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;

  int testCount = 0;
  int failCount = 0;

  // model: an access in flight (if any), who won last, done/rdata seen by each port, memory contents
  bit         mBusy;
  bit         mLast;
  bit         mOwner;
  bit         mWe;
  logic [4:0] mAddr;
  logic [7:0] mData;
  bit         mDone [2];
  logic [7:0] mRdata [2];
  logic [7:0] modelMem [32];
  bit         lastGnt [2];
  bit         autoDrop;
  logic       obsGntA, obsGntB, obsDoneA, obsDoneB, obsWen;

  always #5 clk = ~clk;

  reg_mem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .done_a(done_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .done_b(done_b), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  reg_mem #(8, 5) u_mem (
    .clk(clk), .wen(mem_wen), .addr(mem_addr), .data_in(mem_wdata), .data_out(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic dropReq(input bit port);
    if (port == 1'b0) begin
      req_a = 1'b0; we_a = $urandom_range(0, 1);
      addr_a = 5'($urandom); wdata_a = 8'($urandom);
    end else begin
      req_b = 1'b0; we_b = $urandom_range(0, 1);
      addr_b = 5'($urandom); wdata_b = 8'($urandom);
    end
  endtask

  // one clock cycle: check all outputs mid-cycle against the model, then advance the model
  task automatic applyStimulus();
    bit         nextDone [2];
    logic [4:0] expAddr;
    logic [7:0] expWdata;
    @(negedge clk);
    lastGnt[0] = rst_n && !mBusy && req_a && (!req_b || mLast);
    lastGnt[1] = rst_n && !mBusy && req_b && !lastGnt[0];
    expAddr  = mBusy ? mAddr : 5'd0;
    expWdata = mBusy ? mData : 8'd0;
    obsGntA = gnt_a; obsGntB = gnt_b; obsDoneA = done_a; obsDoneB = done_b; obsWen = mem_wen;
    checkOutput("gnt_a", gnt_a, lastGnt[0]);
    checkOutput("gnt_b", gnt_b, lastGnt[1]);
    checkOutput("done_a", done_a, mDone[0]);
    checkOutput("done_b", done_b, mDone[1]);
    checkOutput("rdata_a", rdata_a, mRdata[0]);
    checkOutput("rdata_b", rdata_b, mRdata[1]);
    checkOutput("mem_wen", mem_wen, mBusy && mWe && rst_n);
    checkOutput("mem_addr", mem_addr, expAddr);
    checkOutput("mem_wdata", mem_wdata, expWdata);
    if (!rst_n) begin
      mBusy = 0; mLast = 1; mDone = '{0, 0}; mRdata = '{8'd0, 8'd0};
    end else begin
      nextDone = '{0, 0};
      if (mBusy) begin
        if (mWe) modelMem[mAddr] = mData;
        else mRdata[mOwner] = modelMem[mAddr];
        nextDone[mOwner] = 1;
        mBusy = 0;
      end else if (lastGnt[0] || lastGnt[1]) begin
        mBusy  = 1;
        mOwner = lastGnt[1];
        mLast  = lastGnt[1];
        mWe    = lastGnt[1] ? we_b : we_a;
        mAddr  = lastGnt[1] ? addr_b : addr_a;
        mData  = lastGnt[1] ? wdata_b : wdata_a;
      end
      mDone = nextDone;
    end
    @(posedge clk);
    #1;
    if (autoDrop) begin
      if (lastGnt[0]) dropReq(1'b0);
      if (lastGnt[1]) dropReq(1'b1);
    end
  endtask

  task automatic resetDut(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) applyStimulus();
    rst_n = 1'b1;
  endtask

  // issue one request and run until its done cycle has been checked
  task automatic doAccess(input bit port, input bit we, input logic [4:0] addr, input logic [7:0] data);
    int n = 0;
    if (port == 1'b0) begin req_a = 1; we_a = we; addr_a = addr; wdata_a = data; end
    else begin req_b = 1; we_b = we; addr_b = addr; wdata_b = data; end
    while (!mDone[port] && n < 8) begin
      applyStimulus();
      n++;
    end
    if (!mDone[port]) checkOutput("access_timeout", 32'd0, 32'd1);
    else applyStimulus();
  endtask

  initial begin
    int n;
    mBusy = 0; mLast = 1; mOwner = 0; mWe = 0; mAddr = '0; mData = '0;
    mDone = '{0, 0}; mRdata = '{8'd0, 8'd0};
    autoDrop = 1;
    rst_n = 0;
    req_a = 1; we_a = 1; addr_a = 5'd7; wdata_a = 8'h5A;
    req_b = 1; we_b = 1; addr_b = 5'd8; wdata_b = 8'hC3;

    // reset held with both ports requesting
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("rst_gnt", {obsGntA, obsGntB}, 2'b00);
      checkOutput("rst_wen", obsWen, 1'b0);
    end
    rst_n = 1;
    req_a = 0; req_b = 0;

    for (int a = 0; a < 32; a++) doAccess(1'b0, 1'b1, 5'(a), 8'($urandom));

    doAccess(1'b0, 1'b1, 5'd5, 8'hA5);
    doAccess(1'b0, 1'b0, 5'd5, 8'h00);
    checkOutput("rd_a_5", rdata_a, 8'hA5);

    // both held from reset: A,B,A,B, each grant on the cycle of the previous done
    resetDut(1);
    autoDrop = 0;
    req_a = 1; we_a = 0; addr_a = 5'd5;
    req_b = 1; we_b = 0; addr_b = 5'd6;
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      checkOutput("alt_gnt_a", obsGntA, (k % 4) == 0);
      checkOutput("alt_gnt_b", obsGntB, (k % 4) == 2);
      checkOutput("alt_done_a", obsDoneA, (k % 4) == 2);
      checkOutput("alt_done_b", obsDoneB, k > 0 && (k % 4) == 0);
    end
    autoDrop = 1;
    req_a = 0; req_b = 0;
    applyStimulus();
    applyStimulus();

    doAccess(1'b1, 1'b1, 5'd31, 8'hFF);
    doAccess(1'b1, 1'b1, 5'd0, 8'h01);
    doAccess(1'b0, 1'b0, 5'd31, 8'h00);
    checkOutput("rd_a_31", rdata_a, 8'hFF);
    doAccess(1'b0, 1'b0, 5'd0, 8'h00);
    checkOutput("rd_a_0", rdata_a, 8'h01);

    // write aborted by reset during its ACCESS cycle
    doAccess(1'b0, 1'b1, 5'd3, 8'h22);
    req_a = 1; we_a = 1; addr_a = 5'd3; wdata_a = 8'h11;
    applyStimulus();
    checkOutput("abort_gnt", obsGntA, 1'b1);
    rst_n = 0;
    applyStimulus();
    checkOutput("abort_wen", obsWen, 1'b0);
    rst_n = 1;
    applyStimulus();
    checkOutput("abort_done", obsDoneA, 1'b0);
    doAccess(1'b0, 1'b0, 5'd3, 8'h00);
    checkOutput("rd_a_3", rdata_a, 8'h22);

    // contention right after reset: A's write to 9 goes first, B then reads the new value
    resetDut(1);
    req_a = 1; we_a = 1; addr_a = 5'd9; wdata_a = 8'h3C;
    req_b = 1; we_b = 0; addr_b = 5'd9; wdata_b = 8'h00;
    n = 0;
    while (!mDone[1] && n < 10) begin applyStimulus(); n++; end
    if (!mDone[1]) checkOutput("cont_timeout", 32'd0, 32'd1);
    else applyStimulus();
    checkOutput("cont_rd_b", rdata_b, 8'h3C);

    // random traffic, occasionally withdrawing a request that has not yet been granted
    for (int c = 0; c < 400; c++) begin
      if (!req_a && $urandom_range(0, 2) == 0) begin
        req_a = 1; we_a = $urandom_range(0, 1); addr_a = 5'($urandom); wdata_a = 8'($urandom);
      end else if (req_a && $urandom_range(0, 15) == 0) dropReq(1'b0);
      if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1; we_b = $urandom_range(0, 1); addr_b = 5'($urandom); wdata_b = 8'($urandom);
      end else if (req_b && $urandom_range(0, 15) == 0) dropReq(1'b1);
      if (c % 97 == 96) rst_n = 0;
      applyStimulus();
      rst_n = 1;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
